if_fetch: RTL and testbench

Parametrised instruction-fetch unit that replaces the bare PC register feeding the instruction ROM. It issues sequential fetches to a fixed-latency ROM, buffers returned instructions with their PCs in a small prefetch FIFO, and hands them to decode over a valid/ready handshake. It supports downstream stall and branch redirect, flushing in-flight and buffered fetches. It sits between the instruction ROM and the ID stage in the core top.

---
 rtl/if_fetch_pkg.sv | 13 +
 rtl/if_fetch_fifo.sv | 80 ++++++++
 rtl/if_fetch.sv | 109 ++++++++++
 tb/tb_if_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants for the instruction-fetch unit.
//   INST_ADDR_BUS / INST_BUS : default PC and instruction widths
//   FETCH_DEPTH / ROM_LATENCY: default prefetch depth and ROM read latency
//   PC_STEP                  : sequential fetch increment in bytes
//   RST_ENABLE               : level of rst that holds the block in reset
package if_fetch_pkg;
  localparam int   INST_ADDR_BUS = 32;
  localparam int   INST_BUS      = 32;
  localparam int   FETCH_DEPTH   = 4;
  localparam int   ROM_LATENCY   = 1;
  localparam int   PC_STEP       = 4;
  localparam logic RST_ENABLE    = 1'b0;
endpackage

// File: rtl/if_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, inst} with a registered head.
//   clk, rst  : clock, async active-low reset
//   i_push    : write i_data this cycle
//   i_pop     : consume head (ignored when empty)
//   i_flush   : drop every entry and any same-cycle push
//   o_head    : head entry (flop), zero when empty
//   o_valid   : head valid (flop)
//   o_empty   : no entries
//   o_count   : entries held, log2(DEPTH)+1 bits
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = FETCH_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd, r_wr;
  logic [PTR_W:0]   r_cnt;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_pop;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W:0]   w_cnt_nxt, w_left;

  assign w_pop     = i_pop && r_valid;
  assign w_rd_nxt  = r_rd + PTR_W'(w_pop);
  // entries still held after the pop, before the push lands
  assign w_left    = r_cnt - (PTR_W+1)'(w_pop);
  assign w_cnt_nxt = w_left + (PTR_W+1)'(i_push);

  // storage needs no reset; only entries covered by r_cnt are ever read
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      // next head: nothing, the entry being pushed (FIFO drains to it), or storage
      if (w_cnt_nxt == '0)  r_head <= '0;
      else if (w_left == '0) r_head <= i_data;
      else                   r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_empty = !r_valid;
  assign o_count = r_cnt;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch unit between the instruction ROM and decode.
//   clk, rst          : clock, async active-low reset
//   rom_addr_o/ce_o   : registered fetch address / request strobe
//   rom_data_i        : ROM data, ROM_LAT cycles after the request
//   branch_flag_i     : redirect; flushes in-flight and buffered fetches
//   branch_target_i   : redirect address (used unaligned as given)
//   inst_o/inst_pc_o  : head instruction and its PC
//   inst_valid_o      : head valid
//   inst_ready_i      : decode accepts head
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              ADDR_W   = INST_ADDR_BUS,
  parameter int              DATA_W   = INST_BUS,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter int              ROM_LAT  = ROM_LATENCY,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 4;

  logic [ADDR_W-1:0]              r_pc, r_addr;
  logic                           r_ce;
  logic [ROM_LAT-1:0]             r_pipe_vld;
  logic [ROM_LAT-1:0][ADDR_W-1:0] r_pipe_pc;

  logic [CNT_W-1:0]         w_fifo_cnt;
  logic [SUM_W-1:0]         w_used;
  logic                     w_issue, w_push, w_pop, w_empty;
  logic [ADDR_W+DATA_W-1:0] w_head;

  // Credit: buffered + outstanding (strobe on the bus plus pipe slots) must
  // stay below DEPTH. Only registered state is counted, so a pop this cycle
  // frees its slot one cycle later and the FIFO can never overflow.
  always_comb begin
    w_used = SUM_W'(w_fifo_cnt) + SUM_W'(r_ce);
    for (int i = 0; i < ROM_LAT; i++) w_used = w_used + SUM_W'(r_pipe_vld[i]);
    w_issue = !branch_flag_i && (w_used < SUM_W'(DEPTH));
  end

  assign w_push = r_pipe_vld[ROM_LAT-1];
  assign w_pop  = inst_ready_i && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_ce       <= 1'b0;
      r_pipe_vld <= '0;
      r_pipe_pc  <= '0;
    end else begin
      // pipe slot 0 follows the request on the bus; the last slot lines up with rom_data_i
      r_pipe_pc[0] <= r_addr;
      for (int i = 1; i < ROM_LAT; i++) r_pipe_pc[i] <= r_pipe_pc[i-1];
      if (branch_flag_i) begin
        // Nothing from the old stream issues; the redirect itself launches
        // the target fetch so it sits on the ROM bus the following cycle.
        r_ce       <= 1'b1;
        r_addr     <= branch_target_i;
        r_pc       <= branch_target_i + ADDR_W'(PC_STEP);
        r_pipe_vld <= '0;
      end else begin
        r_ce          <= w_issue;
        r_pipe_vld[0] <= r_ce;
        for (int i = 1; i < ROM_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        if (w_issue) begin
          r_addr <= r_pc;
          r_pc   <= r_pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  // flush also drops a ROM response landing in the redirect cycle
  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_pipe_pc[ROM_LAT-1], rom_data_i}),
    .i_pop   (w_pop),
    .i_flush (branch_flag_i),
    .o_head  (w_head),
    .o_valid (inst_valid_o),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  assign rom_addr_o = r_addr;
  assign rom_ce_o   = r_ce;
  assign inst_pc_o  = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign inst_o     = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 8;
  localparam int          LAT    = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rom_addr_o;
  logic          rom_ce_o;
  logic [DW-1:0] rom_data_i;
  logic          branch_flag_i = 1'b0;
  logic [AW-1:0] branch_target_i = '0;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_valid_o;
  logic          inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ROM_LAT(LAT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .rom_data_i(rom_data_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
  );

  // ROM contents: a fixed scramble of the address
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // fixed-latency ROM; not reset, so stale addresses survive a DUT reset
  logic [31:0] rom_q [LAT];
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) rom_q[i] <= rom_q[i-1];
    rom_q[0] <= rom_addr_o;
  end
  assign rom_data_i = rom_f(rom_q[LAT-1]);

  int cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int          n_chk = 0, n_fail = 0, n_xfer = 0, last_redir = 0;
  logic [31:0] redir_tgt, exp_issue, pc_pop;
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the decode stream is RESET_PC, +4, +4 ... and restarts
  // at the target after every redirect (reset counts as a redirect at cycle 0).
  // exp_q holds the next PC decode must see.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ce", rom_ce_o, 0);
      chk("rst_addr", rom_addr_o, RST_PC);
      chk("rst_valid", inst_valid_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_pc", inst_pc_o, 0);
      exp_q.delete();
      exp_q.push_back(RST_PC);
      last_redir = 0;
      redir_tgt  = RST_PC;
      exp_issue  = RST_PC;
    end else begin
      if (cyc > last_redir && cyc < last_redir + 2 + LAT) chk("redir_bubble", inst_valid_o, 0);
      if (cyc == last_redir + 2 + LAT) chk("redir_latency", inst_valid_o, 1);
      if (cyc == last_redir + 1) begin
        chk("redir_ce", rom_ce_o, 1);
        chk("redir_addr", rom_addr_o, redir_tgt);
      end
      if (rom_ce_o) begin
        chk("issue_addr", rom_addr_o, exp_issue);
        exp_issue = exp_issue + 32'd4;
      end
      if (inst_valid_o) begin
        chk("head_pc", inst_pc_o, exp_q[0]);
        chk("head_inst", inst_o, rom_f(exp_q[0]));
        if (inst_ready_i) begin
          pc_pop = exp_q.pop_front();
          n_xfer++;
          if (exp_q.size() == 0) exp_q.push_back(pc_pop + 32'd4);
        end
      end
      // a transfer in the branch cycle was consumed above; everything else is gone
      if (branch_flag_i) begin
        last_redir = cyc;
        redir_tgt  = branch_target_i;
        exp_issue  = branch_target_i;
        exp_q.delete();
        exp_q.push_back(branch_target_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_cyc(input int c);
    for (int k = 0; k < 1000 && cyc < c; k++) step();
  endtask

  task automatic branch(input logic [31:0] t);
    branch_flag_i   = 1'b1;
    branch_target_i = t;
    step();
    branch_flag_i   = 1'b0;
  endtask

  int nce, b, pct;

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;

    // streaming from reset, then branch while PC 0x8 transfers at cycle 6
    inst_ready_i = 1'b1;
    go_cyc(6);
    chk("xfer_pc8", inst_pc_o, 32'h8);
    branch(32'h100);
    repeat (12) step();

    // stall: exactly DEPTH requests, then in-order drain and sequential resume
    inst_ready_i = 1'b0;
    branch(32'h200);
    nce = 0;
    repeat (30) begin
      @(negedge clk);
      if (rom_ce_o) nce++;
    end
    chk("stall_reqs", nce, DEPTH);
    step();
    inst_ready_i = 1'b1;
    repeat (20) step();

    // throughput across the address wrap
    b = cyc;
    branch(32'hFFFF_FFF0);
    repeat (20) begin
      @(negedge clk);
      if (cyc >= b + 2 + LAT) chk("throughput", inst_valid_o, 1);
    end

    // back-to-back redirects (last wins), then an unaligned target
    branch(32'h300);
    branch(32'h400);
    repeat (10) step();
    branch(32'h1002);
    repeat (10) step();

    // reset mid-stream
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ce", rom_ce_o, 0);
    chk("midrst_addr", rom_addr_o, RST_PC);
    chk("midrst_valid", inst_valid_o, 0);
    chk("midrst_inst", inst_o, 0);
    chk("midrst_pc", inst_pc_o, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (15) step();

    // random ready / redirect mix
    for (int k = 0; k < 2500; k++) begin
      case ((k / 250) % 4)
        0: pct = 100;
        1: pct = 70;
        2: pct = 30;
        default: pct = 5;
      endcase
      inst_ready_i = ($urandom_range(99) < pct);
      branch_flag_i = ($urandom_range(99) < 4);
      case ($urandom_range(7))
        0: branch_target_i = $urandom;
        1: branch_target_i = 32'hFFFF_FFF8;
        default: branch_target_i = $urandom & 32'h0000_FFFC;
      endcase
      step();
    end
    branch_flag_i = 1'b0;
    inst_ready_i  = 1'b1;
    repeat (20) step();

    chk("enough_xfers", (n_xfer > 500), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
